// File: rtl/stg1if_q.sv
// ---------------------------------------------------------------------------
// stg1if_q - instruction-fetch stage with an in-order prefetch queue
//
// Holds up to DEPTH {pc, instr} pairs returned by instruction memory and
// presents the oldest one to decode through a valid/ready handshake.
//
// Ports
//   iw_clk       : clock, all state updates on the rising edge
//   iw_rst_n     : asynchronous active-low reset
//   iw_mem_data  : instruction word returned by memory
//   iw_ia_valid  : iw_mem_data / iw_pc are valid this cycle
//   iw_pc        : address of iw_mem_data
//   ow_ia_ready  : queue can accept an entry this cycle
//   iw_flush     : discard every queued entry (branch / redirect)
//   ow_valid     : head entry valid toward decode
//   iw_ready     : decode accepts the head entry
//   ow_pc        : pc of the head entry (0 when empty)
//   ow_instr     : instruction of the head entry (0 when empty)
//   ow_count     : current occupancy, 0..DEPTH
//   ow_drop      : one-cycle pulse after an offer was refused because full
// ---------------------------------------------------------------------------
module stg1if_q #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic [DATA_W-1:0] iw_mem_data,
    input  logic              iw_ia_valid,
    input  logic [ADDR_W-1:0] iw_pc,
    output logic              ow_ia_ready,
    input  logic              iw_flush,
    output logic              ow_valid,
    input  logic              iw_ready,
    output logic [ADDR_W-1:0] ow_pc,
    output logic [DATA_W-1:0] ow_instr,
    output logic [CNT_W-1:0]  ow_count,
    output logic              ow_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
    logic [DATA_W-1:0] instr_mem_q [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drop_q, drop_d;

    logic push;
    logic pop;

    // Ready and valid come only from the registered count, so decode's
    // iw_ready never reaches the memory side combinationally.
    assign ow_ia_ready = (count_q != FULL_CNT);
    assign ow_valid    = (count_q != '0);
    assign ow_count    = count_q;
    assign ow_drop     = drop_q;

    // Flush overrides both handshakes in the same cycle.
    assign push = iw_ia_valid & ow_ia_ready & ~iw_flush;
    assign pop  = ow_valid & iw_ready & ~iw_flush;

    // Empty queue shows a zero instruction so stale array contents never leak.
    assign ow_pc    = ow_valid ? pc_mem_q[rptr_q]    : '0;
    assign ow_instr = ow_valid ? instr_mem_q[rptr_q] : '0;

    // Next-state for pointers, occupancy and the overflow pulse.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        drop_d  = iw_ia_valid & ~ow_ia_ready & ~iw_flush;

        if (iw_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state, cleared immediately by reset.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Storage array is deliberately not reset; the output mask hides it.
    always_ff @(posedge iw_clk) begin
        if (push) begin
            pc_mem_q[wptr_q]    <= iw_pc;
            instr_mem_q[wptr_q] <= iw_mem_data;
        end
    end

endmodule

// File: doc/stg1if_q.md
# stg1if_q

Parametrised instruction-fetch stage with a small in-order prefetch queue. It replaces the single-entry fetch latch with a `DEPTH`-entry FIFO of {pc, instr} pairs. This decouples memory returns from the decode stage using a valid/ready handshake, and adds flush and overflow reporting. It sits between the instruction-memory port and stage 2 (decode).

## Interface

Parameters:
- `ADDR_W`, default 24: width of pc.
- `DATA_W`, default 24: width of an instruction word.
- `DEPTH`, default 4: queue entries. Must be a power of two and at least 2.
- `CNT_W`, default $clog2(DEPTH+1): width of the occupancy count.

Ports:
- `iw_clk`, in, 1: the single clock; all state updates on the rising edge.
- `iw_rst_n`, in, 1: reset, asynchronous, active-low.
- `iw_mem_data`, in, DATA_W: instruction word returned by memory.
- `iw_ia_valid`, in, 1: `iw_mem_data`/`iw_pc` valid this cycle.
- `iw_pc`, in, ADDR_W: address of `iw_mem_data`.
- `ow_ia_ready`, out, 1: queue can accept an entry this cycle.
- `iw_flush`, in, 1: discard all queued entries (branch or redirect).
- `ow_valid`, out, 1: head entry valid toward decode.
- `iw_ready`, in, 1: decode accepts the head entry.
- `ow_pc`, out, ADDR_W: pc of the head entry.
- `ow_instr`, out, DATA_W: instruction of the head entry.
- `ow_count`, out, CNT_W: current occupancy, 0..DEPTH.
- `ow_drop`, out, 1: one-cycle pulse; an offered entry was lost because the queue was full.

## Operation

- Storage: `DEPTH` × (ADDR_W+DATA_W) array, write pointer, read pointer (log2 DEPTH bits, natural wrap), and a count register.
- Push condition: `iw_ia_valid & ow_ia_ready & ~iw_flush`. The entry is written at the write pointer; the write pointer increments.
- Pop condition: `ow_valid & iw_ready & ~iw_flush`. The read pointer increments.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- `ow_ia_ready` = (count != DEPTH). It is a pure function of registered state and does not depend on `iw_ready`, so there is no combinational path from decode to memory.
- `ow_valid` = (count != 0).
- `ow_pc` and `ow_instr` show the array entry at the read pointer when `ow_valid` = 1. Both are forced to 0 when empty, giving a bubble as a zero instruction.
- Flush has priority over everything:
  - Pointers and count clear to 0 on that edge.
  - A same-cycle push is discarded.
  - A same-cycle pop does not count.
  - `ow_drop` is not raised for the discarded push.
- Overflow: `iw_ia_valid & ~ow_ia_ready & ~iw_flush` sets `ow_drop` = 1 for exactly the next cycle. Queue contents are unchanged.
- Array contents are not reset; the output masking makes this invisible.

## Timing

- Reset (`iw_rst_n` = 0, asynchronous, immediate):
  - count = 0, pointers = 0.
  - `ow_valid` = 0, `ow_pc` = 0, `ow_instr` = 0.
  - `ow_drop` = 0, `ow_ia_ready` = 1, `ow_count` = 0.
- Reset asserted mid-operation drops all entries. The first edge after release behaves as an empty queue.
- Latency: an entry pushed at edge N is visible on `ow_pc`/`ow_instr` with `ow_valid` = 1 after edge N. This is one cycle, the same as the old latch.
- Order is strict FIFO. Throughput is one push and one pop per cycle.
- Empty, push and pop in the same cycle: no pop occurs because `ow_valid` = 0. The entry appears next cycle.
- Full, push attempt and pop in the same cycle: the push is refused (`ow_ia_ready` = 0) and `ow_drop` pulses. The pop proceeds and count becomes DEPTH−1.
- Pointer wrap from DEPTH−1 to 0 is seamless. Count alone distinguishes full from empty.
- `ow_drop` is registered and rises one cycle after the refused offer.

## Test plan

- Reset then idle:
  - Required: all outputs at their reset values.
  - Required: `ow_ia_ready` = 1 and `ow_count` = 0 throughout.
- Single entry:
  - Stimulus: push pc=0x000010, instr=0xA5A5A5 at edge 1, with `iw_ready` = 1.
  - Required: after edge 1, `ow_valid` = 1 with those values.
  - Required: after edge 2, `ow_valid` = 0 and both outputs read 0.
- Fill and overflow with DEPTH=4 and `iw_ready` = 0:
  - Stimulus: push pc 0,1,2,3, then offer pc 4.
  - Required: `ow_count` = 4 and `ow_ia_ready` = 0.
  - Required: `ow_drop` pulses for one cycle.
  - Required: draining yields pc 0,1,2,3 in order; pc 4 never appears.
- Wrap-around:
  - Stimulus: 10 consecutive cycles with push and pop both active, pc = 0x100+i.
  - Required: output sequence matches input one cycle delayed.
  - Required: `ow_count` stays at 1.
- Flush:
  - Stimulus: with 3 entries queued, assert `iw_flush` together with a push of pc=0x200.
  - Required: next cycle `ow_count` = 0, `ow_valid` = 0, `ow_drop` = 0.
  - Required: pc 0x200 never emerges.
- Asynchronous reset:
  - Stimulus: drop `iw_rst_n` between edges while full.
  - Required: outputs clear before the next edge.
  - Required: after release, a new push appears one cycle later with the correct values.
